// File: rtl/input_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_sequencer_pkg
// Description : Shared constants for the ALU input sequencer (widths, FSM codes)
// Revision    : 1.0 - initial release
// ============================================================================
package input_sequencer_pkg;

    localparam int DATA_W  = 6;
    localparam int OP_W    = 2;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_A    = 2'd0;
    localparam logic [STATE_W-1:0] S_B    = 2'd1;
    localparam logic [STATE_W-1:0] S_OP   = 2'd2;
    localparam logic [STATE_W-1:0] S_SHOW = 2'd3;

    // Idle level of an active-low push-button.
    localparam logic KEY_RELEASED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/input_sequencer_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-flop synchroniser, debounce counter and one-cycle press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import input_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synchronised key disagrees with the
    // accepted level; the last disagreeing cycle flips the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
            level_q <= KEY_RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : input_sequencer
// Description : Debounced two-key sequencer latching ALU operands A, B and opcode
// Revision    : 1.0 - initial release
// ============================================================================
module input_sequencer
    import input_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_enter_n,
    input  logic               key_clear_n,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  a_out,
    output logic [DATA_W-1:0]  b_out,
    output logic [OP_W-1:0]    op_out,
    output logic               valid_out,
    output logic [STATE_W-1:0] state_out
);

    logic               enter_press;
    logic               clear_press;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  a_d;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  b_d;
    logic [OP_W-1:0]    op_q;
    logic [OP_W-1:0]    op_d;
    logic               valid_q;
    logic               valid_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_enter_n),
        .press_o (enter_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_clear_n),
        .press_o (clear_press)
    );

    // Clear has priority over a simultaneous enter.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_press) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (enter_press) begin
            case (state_q)
                S_A: begin
                    a_d     = data_in;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = data_in;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = data_in[OP_W-1:0];
                    state_d = S_SHOW;
                end
                default: state_d = S_A;
            endcase
        end
        valid_d = (state_d == S_SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign op_out    = op_q;
    assign valid_out = valid_q;
    assign state_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_sequencer
// Description : Randomised and directed bench for input_sequencer, DEBOUNCE_CYCLES=4
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_sequencer;

    localparam int N = 4;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic       key_enter_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [5:0] data_in     = 6'h00;
    logic [5:0] a_out;
    logic [5:0] b_out;
    logic [1:0] op_out;
    logic       valid_out;
    logic [1:0] state_out;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    input_sequencer #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_enter_n (key_enter_n),
        .key_clear_n (key_clear_n),
        .data_in     (data_in),
        .a_out       (a_out),
        .b_out       (b_out),
        .op_out      (op_out),
        .valid_out   (valid_out),
        .state_out   (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = enter key, 1 = clear key.
    // A key level is accepted once the last N synchronised samples, all taken
    // since the previous acceptance, contradict the current level.
    logic         m_p1    [2];
    logic         m_p2    [2];
    logic         m_lvl   [2];
    logic         m_pulse [2];
    logic [N-1:0] m_win   [2];
    int           m_fill  [2];
    logic [5:0]   m_a;
    logic [5:0]   m_b;
    logic [1:0]   m_op;
    int           m_st;
    logic         m_valid;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p1[k]    = 1'b1;
            m_p2[k]    = 1'b1;
            m_lvl[k]   = 1'b1;
            m_pulse[k] = 1'b0;
            m_win[k]   = '0;
            m_fill[k]  = 0;
        end
        m_a     = 6'h00;
        m_b     = 6'h00;
        m_op    = 2'h0;
        m_st    = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] raw;
        logic       s;
        raw = {key_clear_n, key_enter_n};
        if (m_pulse[1]) begin
            m_a  = 6'h00;
            m_b  = 6'h00;
            m_op = 2'h0;
            m_st = 0;
        end else if (m_pulse[0]) begin
            if (m_st == 0) m_a = data_in;
            if (m_st == 1) m_b = data_in;
            if (m_st == 2) m_op = data_in[1:0];
            m_st = (m_st + 1) % 4;
        end
        m_valid = (m_st == 3);
        for (int k = 0; k < 2; k++) begin
            s        = m_p2[k];
            m_p2[k]  = m_p1[k];
            m_p1[k]  = raw[k];
            m_win[k] = {m_win[k][N-2:0], s};
            m_fill[k]++;
            m_pulse[k] = 1'b0;
            if (m_fill[k] >= N && m_win[k] == {N{~m_lvl[k]}}) begin
                m_lvl[k]   = ~m_lvl[k];
                m_pulse[k] = ~m_lvl[k];
                m_fill[k]  = 0;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a_out",     a_out,     m_a);
            check("model_b_out",     b_out,     m_b);
            check("model_op_out",    op_out,    m_op);
            check("model_valid_out", valid_out, m_valid);
            check("model_state_out", state_out, m_st);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic tick_rand(input int n);
        repeat (n) begin
            tick(1);
            data_in = 6'($urandom);
        end
    endtask

    task automatic press(input bit en, input bit cl, input logic [5:0] d);
        data_in = d;
        if (en) key_enter_n = 1'b0;
        if (cl) key_clear_n = 1'b0;
        tick(N + 4);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        tick(N + 4);
    endtask

    initial begin
        #1;
        rst    = 1'b1;
        chk_en = 1'b1;
        tick(3);
        check("reset_a",     a_out,     6'h00);
        check("reset_b",     b_out,     6'h00);
        check("reset_op",    op_out,    2'h0);
        check("reset_valid", valid_out, 1'b0);
        check("reset_state", state_out, 2'd0);
        rst = 1'b0;
        tick(2);

        // Bouncing enter, then a clean hold: exact acceptance latency.
        data_in = 6'h2A;
        repeat (5) begin
            key_enter_n = 1'b0;
            tick(2);
            key_enter_n = 1'b1;
            tick(2);
        end
        check("bounce_no_pulse", state_out, 2'd0);
        key_enter_n = 1'b0;
        tick(6);
        check("latency_before", state_out, 2'd0);
        tick(1);
        check("latency_state", state_out, 2'd1);
        check("latency_a",     a_out,     6'h2A);
        key_enter_n = 1'b1;
        tick(N + 4);

        // Long hold gives one advance only.
        data_in     = 6'h15;
        key_enter_n = 1'b0;
        tick(100);
        check("hold_state", state_out, 2'd2);
        check("hold_b",     b_out,     6'h15);
        key_enter_n = 1'b1;
        tick(N + 4);
        check("hold_state_after", state_out, 2'd2);

        press(1'b1, 1'b0, 6'h03);
        check("seq_a",     a_out,     6'h2A);
        check("seq_b",     b_out,     6'h15);
        check("seq_op",    op_out,    2'h3);
        check("seq_valid", valid_out, 1'b1);
        check("seq_state", state_out, 2'd3);

        press(1'b1, 1'b0, 6'h3F);
        check("show_state", state_out, 2'd0);
        check("show_valid", valid_out, 1'b0);
        check("show_a",     a_out,     6'h2A);
        check("show_b",     b_out,     6'h15);
        check("show_op",    op_out,    2'h3);

        // Enter and clear together in S_OP.
        press(1'b1, 1'b0, 6'h11);
        press(1'b1, 1'b0, 6'h07);
        check("op_state", state_out, 2'd2);
        press(1'b1, 1'b1, 6'h22);
        check("both_state", state_out, 2'd0);
        check("both_a",     a_out,     6'h00);
        check("both_b",     b_out,     6'h00);
        check("both_op",    op_out,    2'h0);
        check("both_valid", valid_out, 1'b0);

        // Reset in the middle of a debounce in S_B, key held through release.
        press(1'b1, 1'b0, 6'h05);
        check("prerst_state", state_out, 2'd1);
        data_in     = 6'h2C;
        key_enter_n = 1'b0;
        tick(4);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_a",     a_out,     6'h00);
        check("async_rst_state", state_out, 2'd0);
        check("async_rst_valid", valid_out, 1'b0);
        tick(3);
        rst = 1'b0;
        tick(6);
        check("rel_before", state_out, 2'd0);
        tick(1);
        check("rel_state", state_out, 2'd1);
        check("rel_a",     a_out,     6'h2C);
        key_enter_n = 1'b1;
        tick(N + 4);

        // Randomised key activity with bounce, glitches and churning data.
        for (int it = 0; it < 40; it++) begin
            int  kind;
            int  nb;
            bit  en;
            bit  cl;
            kind = int'($urandom_range(0, 9));
            en   = (kind <= 6) || (kind == 9);
            cl   = (kind >= 7);
            nb   = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                key_enter_n = ~en;
                key_clear_n = ~cl;
                tick_rand(int'($urandom_range(1, N - 1)));
                key_enter_n = 1'b1;
                key_clear_n = 1'b1;
                tick_rand(int'($urandom_range(1, N - 1)));
            end
            key_enter_n = ~en;
            key_clear_n = ~cl;
            tick_rand(int'($urandom_range(1, 3 * N)));
            if (it == 25) begin
                #1;
                rst = 1'b1;
                tick_rand(2);
                rst = 1'b0;
            end
            key_enter_n = 1'b1;
            key_clear_n = 1'b1;
            nb = int'($urandom_range(0, 2));
            for (int b = 0; b < nb; b++) begin
                key_enter_n = ~en;
                key_clear_n = ~cl;
                tick_rand(1);
                key_enter_n = 1'b1;
                key_clear_n = 1'b1;
                tick_rand(int'($urandom_range(1, N - 1)));
            end
            tick_rand(int'($urandom_range(N + 3, 2 * N + 4)));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
